// File: rtl/swizzle_pkg.sv
// swizzle_pkg: buffer-state encoding and default sizes shared by
// swizzle_tile_buffer and swizzle_transpose_pp.
package swizzle_pkg;

   localparam int DEF_W      = 40;
   localparam int DEF_AWIDTH = 9;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_FILLING,
      BUF_FULL,
      BUF_DRAINING
   } buf_state_t;

endpackage

// File: rtl/swizzle_tile_buffer.sv
// swizzle_tile_buffer: one W x W bit tile; rows load by index, columns
// shift out LSB-first, rows at or above idx can be zero-padded.
// Ports: clk; load/pad/shift strobes; idx row index (also pad start);
// row_in row word; col = bit 0 of every row (current column word).
module swizzle_tile_buffer
   import swizzle_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int CW = $clog2(DEF_W + 1)
) (
   input  logic          clk,
   input  logic          load,
   input  logic          pad,
   input  logic          shift,
   input  logic [CW-1:0] idx,
   input  logic [W-1:0]  row_in,
   output logic [W-1:0]  col
);

   logic [W-1:0] mem [W];

   // No reset: every tile either overwrites all rows or pads the
   // rows it did not write, and a drained tile is shifted to zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < W; i++) begin
         if (shift) begin
            mem[i] <= mem[i] >> 1;
         end else if (pad && i >= int'(idx)) begin
            mem[i] <= '0;
         end else if (load && i == int'(idx)) begin
            mem[i] <= row_in;
         end
      end
   end

   always_comb begin
      col = '0;
      for (int i = 0; i < W; i++) begin
         col[i] = mem[i][0];
      end
   end

endmodule

// File: rtl/swizzle_transpose_pp.sv
// swizzle_transpose_pp: ping-pong W x W bit transpose; rows in via
// in_valid/in_ready (flush pads a partial tile), columns out as writes.
// Ports: clk, reset; in_valid, in_ready, ram_data_in, flush;
// mem_ctrl_ready, mem_ctrl_we, mem_ctrl_addr, mem_ctrl_data_out, frame_done.
module swizzle_transpose_pp
   import swizzle_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int AWIDTH     = DEF_AWIDTH,
   parameter int START_ADDR = 0,
   parameter int NUM_WORDS  = 480
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      ram_data_in,
   input  logic              flush,
   input  logic              mem_ctrl_ready,
   output logic              mem_ctrl_we,
   output logic [AWIDTH-1:0] mem_ctrl_addr,
   output logic [W-1:0]      mem_ctrl_data_out,
   output logic              frame_done
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
   localparam logic [AWIDTH-1:0] FIRST_ADDR = AWIDTH'(START_ADDR);
   localparam logic [AWIDTH-1:0] LAST_ADDR =
      AWIDTH'(START_ADDR + NUM_WORDS - 1);

   buf_state_t        st     [2];
   buf_state_t        st_nxt [2];
   logic              fill_sel;
   logic [CW-1:0]     row_cnt;
   logic [CW-1:0]     col_cnt;
   logic [AWIDTH-1:0] addr;
   logic [W-1:0]      col [2];
   logic [1:0]        free;
   logic              fill_open;
   logic              in_xfer;
   logic              pad;
   logic              fill_done;
   logic              drain_sel;
   logic              wr_done;
   logic              drain_end;

   assign fill_open = st[fill_sel] == BUF_EMPTY ||
                      st[fill_sel] == BUF_FILLING;
   assign in_ready  = fill_open && !flush;
   assign in_xfer   = in_valid && in_ready;
   assign pad       = flush && st[fill_sel] == BUF_FILLING;
   assign fill_done = pad || (in_xfer && row_cnt == LAST_IDX);

   // At most one buffer drains at a time, so this picks it.
   assign drain_sel   = st[1] == BUF_DRAINING;
   assign mem_ctrl_we = st[0] == BUF_DRAINING ||
                        st[1] == BUF_DRAINING;
   assign wr_done     = mem_ctrl_we && mem_ctrl_ready;
   assign drain_end   = wr_done && col_cnt == LAST_IDX;

   assign mem_ctrl_addr     = addr;
   assign mem_ctrl_data_out = mem_ctrl_we ? col[drain_sel] : '0;
   assign frame_done        = wr_done && addr == LAST_ADDR;

   // A buffer may start draining when its partner is not draining or
   // finishes this very cycle; that hand-off keeps the output gap-free.
   assign free[0] = st[1] != BUF_DRAINING || drain_end;
   assign free[1] = st[0] != BUF_DRAINING || drain_end;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         st_nxt[b] = st[b];
         unique case (st[b])
            BUF_EMPTY, BUF_FILLING: begin
               if (fill_sel == 1'(b)) begin
                  // FULL is skipped when the tile can drain at once.
                  if (fill_done) begin
                     st_nxt[b] = free[b] ? BUF_DRAINING : BUF_FULL;
                  end else if (in_xfer) begin
                     st_nxt[b] = BUF_FILLING;
                  end
               end
            end
            BUF_FULL: begin
               if (free[b]) st_nxt[b] = BUF_DRAINING;
            end
            BUF_DRAINING: begin
               if (drain_end) st_nxt[b] = BUF_EMPTY;
            end
            default: st_nxt[b] = BUF_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st[0] <= BUF_EMPTY;
         st[1] <= BUF_EMPTY;
      end else begin
         st[0] <= st_nxt[0];
         st[1] <= st_nxt[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_sel <= 1'b0;
         row_cnt  <= '0;
         col_cnt  <= '0;
         addr     <= FIRST_ADDR;
      end else begin
         if (fill_done) fill_sel <= ~fill_sel;

         if (fill_done) row_cnt <= '0;
         else if (in_xfer) row_cnt <= row_cnt + 1'b1;

         if (drain_end) col_cnt <= '0;
         else if (wr_done) col_cnt <= col_cnt + 1'b1;

         if (wr_done) begin
            addr <= (addr == LAST_ADDR) ? FIRST_ADDR : addr + 1'b1;
         end
      end
   end

   swizzle_tile_buffer #(.W(W), .CW(CW)) u_ping (
      .clk    (clk),
      .load   (in_xfer && !fill_sel),
      .pad    (pad && !fill_sel),
      .shift  (wr_done && !drain_sel),
      .idx    (row_cnt),
      .row_in (ram_data_in),
      .col    (col[0])
   );

   swizzle_tile_buffer #(.W(W), .CW(CW)) u_pong (
      .clk    (clk),
      .load   (in_xfer && fill_sel),
      .pad    (pad && fill_sel),
      .shift  (wr_done && drain_sel),
      .idx    (row_cnt),
      .row_in (ram_data_in),
      .col    (col[1])
   );

endmodule

// File: tb/tb_swizzle_transpose_pp.sv
// tb_swizzle_transpose_pp: table vectors plus hand sequences, with a
// write scoreboard for swizzle_transpose_pp at W=4, NUM_WORDS=8.
module tb_swizzle_transpose_pp;

   localparam int W  = 4;
   localparam int AW = 4;
   localparam int NW = 8;

   typedef logic [W-1:0] row_t;

   typedef struct packed {
      logic [3:0][W-1:0] rows;
      logic [2:0]        nrows;
      logic              do_flush;
      logic [3:0][W-1:0] exp;
   } vec_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      row_t          data;
      logic          fd;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   row_t          ram_data_in;
   logic          flush;
   logic          mem_ctrl_ready;
   logic          mem_ctrl_we;
   logic [AW-1:0] mem_ctrl_addr;
   row_t          mem_ctrl_data_out;
   logic          frame_done;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   wr_count = 0;
   int   model_addr = 0;
   int   acc_cyc = 0;
   wr_t  sb [$];
   int   wr_cyc [$];
   vec_t vecs [4];

   swizzle_transpose_pp #(
      .W(W), .AWIDTH(AW), .START_ADDR(0), .NUM_WORDS(NW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .ram_data_in       (ram_data_in),
      .flush             (flush),
      .mem_ctrl_ready    (mem_ctrl_ready),
      .mem_ctrl_we       (mem_ctrl_we),
      .mem_ctrl_addr     (mem_ctrl_addr),
      .mem_ctrl_data_out (mem_ctrl_data_out),
      .frame_done        (frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   wr_t  e;
   logic prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   row_t prev_data;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_we", 32'(mem_ctrl_we), 1);
            check("hold_addr", 32'(mem_ctrl_addr), 32'(prev_addr));
            check("hold_data", 32'(mem_ctrl_data_out), 32'(prev_data));
         end
         prev_stall = mem_ctrl_we && !mem_ctrl_ready;
         prev_addr  = mem_ctrl_addr;
         prev_data  = mem_ctrl_data_out;
         if (mem_ctrl_we && mem_ctrl_ready) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h",
                        mem_ctrl_addr, mem_ctrl_data_out);
            end else begin
               e = sb.pop_front();
               check("wr_addr", 32'(mem_ctrl_addr), 32'(e.addr));
               check("wr_data", 32'(mem_ctrl_data_out), 32'(e.data));
               check("wr_frame_done", 32'(frame_done), 32'(e.fd));
            end
         end else if (frame_done) begin
            fail_now("frame_done_without_write");
         end
      end
   end

   task automatic push_word(input row_t d);
      wr_t w;
      w.addr = AW'(model_addr);
      w.data = d;
      w.fd   = (model_addr == NW - 1);
      sb.push_back(w);
      model_addr = (model_addr + 1) % NW;
   endtask

   task automatic push_tile(input logic [3:0][W-1:0] r);
      row_t w;
      for (int j = 0; j < W; j++) begin
         for (int i = 0; i < W; i++) w[i] = r[i][j];
         push_word(w);
      end
   endtask

   task automatic send_row(input row_t d);
      int n;
      n = 0;
      in_valid    = 1'b1;
      ram_data_in = d;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) fail_now("send_row_timeout");
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush       = 1'b1;
      in_valid    = 1'b1;
      ram_data_in = 4'hF;
      @(negedge clk);
      check("flush_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_we"}, 32'(mem_ctrl_we), 0);
      check({tag, "_addr"}, 32'(mem_ctrl_addr), 0);
      check({tag, "_data"}, 32'(mem_ctrl_data_out), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_in_ready"}, 32'(in_ready), 1);
   endtask

   task automatic stall_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!(mem_ctrl_we && mem_ctrl_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      mem_ctrl_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mem_ctrl_ready = 1'b1;
   endtask

   logic [7:0][W-1:0] rr;
   int base;
   int n;

   initial begin
      vecs[0].rows = {4'h8, 4'h4, 4'h2, 4'h1};
      vecs[0].nrows = 4; vecs[0].do_flush = 0;
      vecs[0].exp  = {4'h8, 4'h4, 4'h2, 4'h1};
      vecs[1].rows = {4'h0, 4'hF, 4'h0, 4'hF};
      vecs[1].nrows = 4; vecs[1].do_flush = 0;
      vecs[1].exp  = {4'h5, 4'h5, 4'h5, 4'h5};
      vecs[2].rows = {4'h0, 4'h0, 4'hF, 4'hF};
      vecs[2].nrows = 2; vecs[2].do_flush = 1;
      vecs[2].exp  = {4'h3, 4'h3, 4'h3, 4'h3};
      vecs[3].rows = {4'h6, 4'h9, 4'h5, 4'h3};
      vecs[3].nrows = 4; vecs[3].do_flush = 0;
      vecs[3].exp  = {4'h4, 4'hA, 4'h9, 4'h7};

      reset = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      ram_data_in = '0;
      mem_ctrl_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1;

      for (int t = 0; t < 4; t++) begin
         if (t == 0) wr_cyc.delete();
         for (int j = 0; j < 4; j++) push_word(vecs[t].exp[j]);
         for (int i = 0; i < int'(vecs[t].nrows); i++)
            send_row(vecs[t].rows[i]);
         if (vecs[t].do_flush) do_flush();
         if (t == 0) begin
            wait_drain();
            if (wr_cyc.size() == 0) fail_now("first_latency_no_write");
            else check("first_latency", wr_cyc[0], acc_cyc);
         end
      end
      wait_drain();

      base = wr_count;
      do_flush();
      repeat (6) @(posedge clk);
      #1;
      check("empty_flush_writes", wr_count - base, 0);
      @(negedge clk);
      check("empty_flush_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) rr[i] = row_t'($urandom);
      wr_cyc.delete();
      push_tile(rr[3:0]);
      push_tile(rr[7:4]);
      for (int i = 0; i < 8; i++) send_row(rr[i]);
      wait_drain();
      check("b2b_count", wr_cyc.size(), 8);
      for (int i = 0; i + 1 < wr_cyc.size(); i++)
         check("b2b_gap", wr_cyc[i+1] - wr_cyc[i], 1);

      for (int i = 0; i < 8; i++) rr[i] = row_t'($urandom);
      push_tile(rr[3:0]);
      for (int i = 0; i < 4; i++) send_row(rr[i]);
      push_tile(rr[7:4]);
      fork
         begin
            for (int i = 4; i < 8; i++) send_row(rr[i]);
            @(negedge clk);
            check("both_full_in_ready", 32'(in_ready), 0);
         end
         stall_ready();
      join
      for (int i = 0; i < 4; i++) rr[i] = row_t'($urandom);
      push_tile(rr[3:0]);
      for (int i = 0; i < 4; i++) send_row(rr[i]);
      wait_drain();

      for (int i = 0; i < 4; i++) rr[i] = row_t'($urandom);
      push_tile(rr[3:0]);
      base = wr_count;
      for (int i = 0; i < 4; i++) send_row(rr[i]);
      n = 0;
      while (wr_count < base + 2 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("pre_reset_writes", wr_count - base, 2);
      reset = 1'b1;
      sb.delete();
      model_addr = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle("mid_reset");
      repeat (10) @(posedge clk);
      #1;
      check("post_reset_writes", wr_count - base, 2);

      for (int i = 0; i < 4; i++) rr[i] = row_t'($urandom);
      push_tile(rr[3:0]);
      for (int i = 0; i < 4; i++) send_row(rr[i]);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
